seg_pipe_adder: RTL and testbench

- Parametrised, segmented, pipelined add/subtract unit.
- WIDTH-bit operands are split into STAGES equal chunks; one chunk is added per pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on both sides; accepts one operation per cycle.
- Used wherever wide additions must close timing at high clock rates; successor to the single-cycle generate-based ripple adder.

---
 rtl/seg_pipe_adder_pkg.sv | 23 ++
 rtl/adder_chunk_stage.sv | 84 ++++++++
 rtl/seg_pipe_adder.sv | 99 +++++++++
 tb/tb_seg_pipe_adder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pipe_adder_pkg.sv
// rtl/seg_pipe_adder_pkg.sv - shared constants and helpers for the segmented pipelined adder
//
// Purpose: default geometry of seg_pipe_adder, chunk-width helper and the
// configuration check used at elaboration.
// Optional feature macro: SEG_PIPE_ADDER_OVF_EN (no package content depends on it).
// Ports: none (package).

package seg_pipe_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Width of one chunk handled by a single pipeline stage.
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal geometry: at least one stage, equal chunks of at least one bit.
  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// rtl/adder_chunk_stage.sv - one registered chunk slice of the segmented adder
//
// Purpose: adds chunk IDX of a_in/b_in plus c_in, registers the CW-bit partial
// sum into its slot of the deskew vector, registers the chunk carry, and
// forwards the operand vectors so later stages still see their upper chunks.
// Optional feature macro: SEG_PIPE_ADDER_OVF_EN adds ovf_out (signed overflow,
// meaningful only in the stage that owns the MSB chunk).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   en                  global advance; every register holds when low
//   valid_in/valid_out  beat valid bit travelling with the data
//   c_in/c_out          carry into / out of this chunk
//   a_in/a_out, b_in/b_out  operand skew vectors (b already inverted for sub)
//   s_in/s_out          deskew vector of already-computed sum chunks
//   ovf_out             (macro only) carry-into-MSB xor carry-out-of-MSB

module adder_chunk_stage
  import seg_pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = chunk_w(DEF_WIDTH, DEF_STAGES),
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_in,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_in,
  output logic             valid_out,
  output logic             c_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] s_out
`ifdef SEG_PIPE_ADDER_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int LO = IDX * CW;

  logic [CW:0]      part;
  logic [WIDTH-1:0] s_next;

  assign part = {1'b0, a_in[LO +: CW]} + {1'b0, b_in[LO +: CW]} + {{CW{1'b0}}, c_in};

  // Drop this chunk's partial sum into its slot; lower slots came from earlier stages.
  always_comb begin
    s_next            = s_in;
    s_next[LO +: CW]  = part[CW-1:0];
  end

`ifdef SEG_PIPE_ADDER_OVF_EN
  // The carry into the top bit of this chunk is recovered as a^b^sum at that bit.
  logic ovf_next;
  assign ovf_next = (a_in[LO+CW-1] ^ b_in[LO+CW-1] ^ part[CW-1]) ^ part[CW];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      c_out     <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      s_out     <= '0;
`ifdef SEG_PIPE_ADDER_OVF_EN
      ovf_out   <= 1'b0;
`endif
    end else if (en) begin
      valid_out <= valid_in;
      c_out     <= part[CW];
      a_out     <= a_in;
      b_out     <= b_in;
      s_out     <= s_next;
`ifdef SEG_PIPE_ADDER_OVF_EN
      ovf_out   <= ovf_next;
`endif
    end
  end

endmodule

// File: rtl/seg_pipe_adder.sv
// rtl/seg_pipe_adder.sv - segmented pipelined add/subtract unit with valid/ready
//
// Purpose: WIDTH-bit a+b+cin or a-b-cin split into STAGES chunks, one chunk per
// pipeline stage, with a single global stall (advance) for all stages.
// Optional feature macro: SEG_PIPE_ADDER_OVF_EN adds output ovf.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand beat handshake (in_ready = advance)
//   a, b, cin, sub        operands; sub=1 selects a-b-cin
//   out_valid/out_ready   result handshake
//   sum, cout             registered result; cout is NOT borrow when sub=1
//   ovf                   (macro only) two's-complement overflow of the beat

module seg_pipe_adder
  import seg_pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEG_PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_bad
    $error("seg_pipe_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Element k feeds stage k; element STAGES is the output register set.
  logic             v_p [STAGES+1];
  logic             c_p [STAGES+1];
  logic [WIDTH-1:0] a_p [STAGES+1];
  logic [WIDTH-1:0] b_p [STAGES+1];
  logic [WIDTH-1:0] s_p [STAGES+1];
`ifdef SEG_PIPE_ADDER_OVF_EN
  logic             ovf_p [STAGES];
`endif

  logic advance;

  // Whole pipe moves together; it only stops when a finished result is blocked.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  assign v_p[0] = in_valid & in_ready;
  assign c_p[0] = sub ? ~cin : cin;
  assign a_p[0] = a;
  assign b_p[0] = sub ? ~b : b;
  assign s_p[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk_stage #(
      .WIDTH (WIDTH),
      .CW    (CW),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance),
      .valid_in  (v_p[k]),
      .c_in      (c_p[k]),
      .a_in      (a_p[k]),
      .b_in      (b_p[k]),
      .s_in      (s_p[k]),
      .valid_out (v_p[k+1]),
      .c_out     (c_p[k+1]),
      .a_out     (a_p[k+1]),
      .b_out     (b_p[k+1]),
      .s_out     (s_p[k+1])
`ifdef SEG_PIPE_ADDER_OVF_EN
      ,
      .ovf_out   (ovf_p[k])
`endif
    );
  end

  assign out_valid = v_p[STAGES];
  assign sum       = s_p[STAGES];
  assign cout      = c_p[STAGES];
`ifdef SEG_PIPE_ADDER_OVF_EN
  assign ovf       = ovf_p[STAGES-1];
`endif

endmodule

// File: tb/tb_seg_pipe_adder.sv
// tb/tb_seg_pipe_adder.sv - self-checking bench for seg_pipe_adder

module tb_seg_pipe_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [W-1:0]  a, b, sum;
  logic          x8_iv, x8_ir, x8_cin, x8_sub, x8_ov, x8_co;
  logic [7:0]    x8_a, x8_b, x8_sum;
  logic          x12_iv, x12_ir, x12_cin, x12_sub, x12_ov, x12_co;
  logic [11:0]   x12_a, x12_b, x12_sum;
`ifdef SEG_PIPE_ADDER_OVF_EN
  logic          ovf, x8_ovf, x12_ovf;
`endif

  seg_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef SEG_PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  seg_pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(x8_iv), .in_ready(x8_ir),
    .a(x8_a), .b(x8_b), .cin(x8_cin), .sub(x8_sub), .out_valid(x8_ov),
    .out_ready(1'b1), .sum(x8_sum), .cout(x8_co)
`ifdef SEG_PIPE_ADDER_OVF_EN
    , .ovf(x8_ovf)
`endif
  );

  seg_pipe_adder #(.WIDTH(12), .STAGES(3)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(x12_iv), .in_ready(x12_ir),
    .a(x12_a), .b(x12_b), .cin(x12_cin), .sub(x12_sub), .out_valid(x12_ov),
    .out_ready(1'b1), .sum(x12_sum), .cout(x12_co)
`ifdef SEG_PIPE_ADDER_OVF_EN
    , .ovf(x12_ovf)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int acc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-width reference: returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                          input logic tc, input logic ts);
    logic [W-1:0] beff;
    logic         c0;
    logic [W:0]   full;
    logic [W-1:0] low;
    beff = ts ? ~tb : tb;
    c0   = ts ? ~tc : tc;
    full = {1'b0, ta} + {1'b0, beff} + {{W{1'b0}}, c0};
    low  = {1'b0, ta[W-2:0]} + {1'b0, beff[W-2:0]} + {{(W-1){1'b0}}, c0};
    return {low[W-1] ^ full[W], full};
  endfunction

  // Model: S result slots that all move together whenever the unit can advance.
  logic          mv [S];
  logic [W+1:0]  mr [S];

  always @(posedge clk) begin : model
    logic adv;
    if (!rst_n) begin
      for (int k = 0; k < S; k++) begin
        mv[k] = 1'b0;
        mr[k] = '0;
      end
    end else begin
      adv = !mv[S-1] || out_ready;
      if (adv) begin
        for (int k = S-1; k > 0; k--) begin
          mv[k] = mv[k-1];
          mr[k] = mr[k-1];
        end
        mv[0] = in_valid;
        mr[0] = ref_op(a, b, cin, sub);
        if (in_valid) acc_cnt++;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(!mv[S-1] || out_ready));
      check("out_valid", 32'(out_valid), 32'(mv[S-1]));
      if (mv[S-1] && out_valid) begin
        check("sum", 32'(sum), 32'(mr[S-1][W-1:0]));
        check("cout", 32'(cout), 32'(mr[S-1][W]));
`ifdef SEG_PIPE_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(mr[S-1][W+1]));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int target;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    x8_iv = 1'b0; x8_a = '0; x8_b = '0; x8_cin = 1'b0; x8_sub = 1'b0;
    x12_iv = 1'b0; x12_a = '0; x12_b = '0; x12_cin = 1'b0; x12_sub = 1'b0;
    step(); step();
    chk_en = 1'b1;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_x8_valid", 32'(x8_ov), 32'd0);
    check("rst_x12_ready", 32'(x12_ir), 32'd1);
    rst_n = 1'b1;

    // FFFF + 1 wraps to 0 with carry, exactly S cycles after acceptance
    a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("t1_not_yet", 32'(out_valid), 32'd0);
    step();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_sum", 32'(sum), 32'h0000);
    check("t1_cout", 32'(cout), 32'd1);
    step();

    // Back-to-back add then subtract with borrow
    a = 16'd14; b = 16'd12; in_valid = 1'b1;
    step();
    a = 16'd10; b = 16'd13; sub = 1'b1; cin = 1'b0;
    step();
    in_valid = 1'b0; sub = 1'b0;
    step(); step();
    check("t2a_valid", 32'(out_valid), 32'd1);
    check("t2a_sum", 32'(sum), 32'd26);
    check("t2a_cout", 32'(cout), 32'd0);
    step();
    check("t2b_valid", 32'(out_valid), 32'd1);
    check("t2b_sum", 32'(sum), 32'hFFFD);
    check("t2b_cout", 32'(cout), 32'd0);
    step();

    // Fill the pipe behind a blocked output, then release
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      step();
    end
    check("fill_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S + 2) step();

    // Random stream with random back-pressure
    target = acc_cnt + 64;
    cyc = 0;
    while (acc_cnt < target && cyc < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      cyc++;
    end
    check("t3_accepted", 32'(acc_cnt >= target), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S + 2) step();

    // Reset with two beats in flight discards them
    a = 16'd1; b = 16'd2; in_valid = 1'b1;
    step();
    a = 16'd3; b = 16'd4;
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t4_flushed", 32'(out_valid), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    repeat (S + 2) step();
    check("t4_no_stale", 32'(out_valid), 32'd0);

    // Other geometries: 8/1 (latency 1) and 12/3 (latency 3)
    x8_a = 8'hC8; x8_b = 8'h64; x8_iv = 1'b1;
    x12_a = 12'hABC; x12_b = 12'h678; x12_iv = 1'b1;
    step();
    x8_iv = 1'b0; x12_iv = 1'b0;
    check("x8_valid", 32'(x8_ov), 32'd1);
    check("x8_sum", 32'(x8_sum), 32'h2C);
    check("x8_cout", 32'(x8_co), 32'd1);
    check("x12_lat1", 32'(x12_ov), 32'd0);
    step();
    check("x12_lat2", 32'(x12_ov), 32'd0);
    check("x8_drained", 32'(x8_ov), 32'd0);
    step();
    check("x12_valid", 32'(x12_ov), 32'd1);
    check("x12_sum", 32'(x12_sum), 32'h134);
    check("x12_cout", 32'(x12_co), 32'd1);
    x12_a = 12'h100; x12_b = 12'h001; x12_sub = 1'b1; x12_cin = 1'b1; x12_iv = 1'b1;
    step();
    x12_iv = 1'b0; x12_sub = 1'b0; x12_cin = 1'b0;
    step(); step();
    check("x12_sub_valid", 32'(x12_ov), 32'd1);
    check("x12_sub_sum", 32'(x12_sum), 32'h0FE);
    check("x12_sub_cout", 32'(x12_co), 32'd1);
    step();

`ifdef SEG_PIPE_ADDER_OVF_EN
    // Signed overflow in both directions
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    a = 16'h8000; b = 16'h0001; sub = 1'b1;
    step();
    in_valid = 1'b0; sub = 1'b0;
    step(); step();
    check("t6a_sum", 32'(sum), 32'h8000);
    check("t6a_ovf", 32'(ovf), 32'd1);
    step();
    check("t6b_sum", 32'(sum), 32'h7FFF);
    check("t6b_ovf", 32'(ovf), 32'd1);
    step();
`endif

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
